// File: rtl/semaforo_cruzamento_param_pkg.sv
// Shared phase encodings and helpers for the N-way
// intersection controller.
package semaforo_pkg;

   localparam int PHASE_W = 3;

   typedef logic [PHASE_W-1:0] phase_t;

   localparam phase_t GREEN  = 3'd0;
   localparam phase_t YELLOW = 3'd1;
   localparam phase_t ALLRED = 3'd2;
   localparam phase_t WALK   = 3'd3;
   localparam phase_t FLASH  = 3'd4;

   // Round-robin successor of a way index
   function automatic logic [2:0] next_way(
      input logic [2:0] w,
      input int         n
   );
      if (int'(w) == n - 1)
         return 3'd0;
      return w + 3'd1;
   endfunction

endpackage

// File: rtl/semaforo_cruzamento_param_if.sv
// Lamp/button bundle between board top and the
// intersection controller.
interface semaforo_cruzamento_param_if #(
   parameter int N_WAYS = 2
);
   import semaforo_pkg::*;

   logic              tick;
   logic [N_WAYS-1:0] botao;
   logic              flash_mode;
   logic [N_WAYS-1:0] light_GREEN;
   logic [N_WAYS-1:0] light_YELLOW;
   logic [N_WAYS-1:0] light_RED;
   logic [N_WAYS-1:0] p_light_GREEN;
   logic [N_WAYS-1:0] p_light_RED;
   logic [2:0]        cur_way;
   phase_t            phase;

   modport master (
      output tick, botao, flash_mode,
      input  light_GREEN, light_YELLOW, light_RED,
      input  p_light_GREEN, p_light_RED,
      input  cur_way, phase
   );

   modport slave (
      input  tick, botao, flash_mode,
      output light_GREEN, light_YELLOW, light_RED,
      output p_light_GREEN, p_light_RED,
      output cur_way, phase
   );

endinterface

// File: rtl/semaforo_cruzamento_param_btn_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse taken
// one flop further down the chain.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [2:0] r_sh;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_sh <= '0;
      else
         r_sh <= {r_sh[1:0], i_async};
   end

   assign o_level = r_sh[1];
   assign o_rise  = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/semaforo_cruzamento_param.sv
// N-approach intersection controller: round-robin
// green, latched ped requests, all-red walk, flash.
module semaforo_cruzamento_param
   import semaforo_pkg::*;
#(
   parameter int N_WAYS      = 2,
   parameter int CNT_W       = 8,
   parameter int T_GREEN     = 20,
   parameter int T_MIN_GREEN = 5,
   parameter int T_YELLOW    = 3,
   parameter int T_ALLRED    = 2,
   parameter int T_WALK      = 8
) (
   input logic                        clk,
   input logic                        reset,
   semaforo_cruzamento_param_if.slave bus
);

   localparam logic [N_WAYS-1:0] ALL1 = '1;
   localparam logic [2:0] LAST_WAY = 3'(N_WAYS - 1);
   localparam logic [CNT_W-1:0] C_GREEN = CNT_W'(T_GREEN);
   localparam logic [CNT_W-1:0] C_MIN = CNT_W'(T_MIN_GREEN);
   localparam logic [CNT_W-1:0] C_YEL = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] C_AR = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] C_WALK = CNT_W'(T_WALK);

   logic [N_WAYS-1:0] w_btn_rise;
   logic              w_flash;
   logic              w_flash_rise_unused;

   phase_t            r_state, w_state_nx;
   logic [CNT_W-1:0]  r_timer, w_timer_nx, w_timer_inc;
   logic [2:0]        r_cur_way, w_cur_way_nx;
   logic [2:0]        r_next_way, w_next_way_nx;
   logic [N_WAYS-1:0] r_req, w_req_nx;
   logic [N_WAYS-1:0] r_walk_mask, w_walk_mask_nx;
   logic              r_blink, w_blink_nx;

   logic [N_WAYS-1:0] w_onehot;
   logic [N_WAYS-1:0] r_g, r_y, r_r, r_pg, r_pr;
   logic [N_WAYS-1:0] w_g, w_y, w_r, w_pg, w_pr;

   for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_btn
      logic w_level_unused;
      btn_sync_edge u_sync (
         .clk     (clk),
         .reset   (reset),
         .i_async (bus.botao[gi]),
         .o_level (w_level_unused),
         .o_rise  (w_btn_rise[gi])
      );
   end

   btn_sync_edge u_flash_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.flash_mode),
      .o_level (w_flash),
      .o_rise  (w_flash_rise_unused)
   );

   assign w_timer_inc = r_timer + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ALLRED;
         r_timer     <= '0;
         r_cur_way   <= '0;
         r_next_way  <= '0;
         r_req       <= '0;
         r_walk_mask <= '0;
         r_blink     <= 1'b0;
         r_g         <= '0;
         r_y         <= '0;
         r_r         <= ALL1;
         r_pg        <= '0;
         r_pr        <= ALL1;
      end else begin
         r_state     <= w_state_nx;
         r_timer     <= w_timer_nx;
         r_cur_way   <= w_cur_way_nx;
         r_next_way  <= w_next_way_nx;
         r_req       <= w_req_nx;
         r_walk_mask <= w_walk_mask_nx;
         r_blink     <= w_blink_nx;
         r_g         <= w_g;
         r_y         <= w_y;
         r_r         <= w_r;
         r_pg        <= w_pg;
         r_pr        <= w_pr;
      end
   end

   // Flash overrides any timer-driven exit
   always_comb begin
      w_state_nx = r_state;
      if (w_flash) begin
         w_state_nx = FLASH;
      end else begin
         unique case (r_state)
            GREEN:
               if (bus.tick && (w_timer_inc == C_GREEN ||
                   (|r_req && w_timer_inc >= C_MIN)))
                  w_state_nx = YELLOW;
            YELLOW:
               if (bus.tick && w_timer_inc == C_YEL)
                  w_state_nx = ALLRED;
            ALLRED:
               if (bus.tick && w_timer_inc == C_AR)
                  w_state_nx = (|r_req) ? WALK : GREEN;
            WALK:
               if (bus.tick && w_timer_inc == C_WALK)
                  w_state_nx = ALLRED;
            FLASH:
               w_state_nx = ALLRED;
            default:
               w_state_nx = ALLRED;
         endcase
      end

      w_cur_way_nx   = r_cur_way;
      w_next_way_nx  = r_next_way;
      w_req_nx       = r_req | w_btn_rise;
      w_walk_mask_nx = r_walk_mask;
      w_blink_nx     = (r_state == FLASH) ?
                       (r_blink ^ bus.tick) : 1'b0;

      if (w_state_nx != r_state)
         w_timer_nx = '0;
      else if (bus.tick)
         w_timer_nx = w_timer_inc;
      else
         w_timer_nx = r_timer;

      // Entry actions
      if (w_state_nx != r_state) begin
         unique case (w_state_nx)
            GREEN: begin
               w_cur_way_nx  = r_next_way;
               w_next_way_nx = next_way(r_next_way, N_WAYS);
            end
            WALK: begin
               w_walk_mask_nx = r_req | w_btn_rise;
               w_req_nx       = '0;
            end
            ALLRED:
               if (r_state == FLASH) begin
                  w_cur_way_nx  = LAST_WAY;
                  w_next_way_nx = 3'd0;
               end
            default: ;
         endcase
      end
   end

   assign w_onehot = N_WAYS'(1) << w_cur_way_nx;

   // Decoded from next-state so lamps track phase
   always_comb begin
      w_g  = '0;
      w_y  = '0;
      w_r  = ALL1;
      w_pg = '0;
      w_pr = ALL1;
      unique case (w_state_nx)
         GREEN: begin
            w_g = w_onehot;
            w_r = ~w_onehot;
         end
         YELLOW: begin
            w_y = w_onehot;
            w_r = ~w_onehot;
         end
         WALK: begin
            w_pg = w_walk_mask_nx;
            w_pr = ~w_walk_mask_nx;
         end
         FLASH: begin
            w_y = {N_WAYS{w_blink_nx}};
            w_r = '0;
         end
         default: ;
      endcase
   end

   assign bus.light_GREEN   = r_g;
   assign bus.light_YELLOW  = r_y;
   assign bus.light_RED     = r_r;
   assign bus.p_light_GREEN = r_pg;
   assign bus.p_light_RED   = r_pr;
   assign bus.cur_way       = r_cur_way;
   assign bus.phase         = r_state;

endmodule

// File: tb/tb_semaforo_cruzamento_param.sv
// Scoreboard bench for the N-way intersection
// controller (2-way and 4-way builds).
module tb_semaforo_cruzamento_param;
   import semaforo_pkg::*;

   typedef struct packed {
      logic [2:0] ph;
      logic [2:0] way;
      logic [7:0] ticks;
      logic [1:0] pm;
   } exp_t;

   logic clk;
   logic reset;
   logic tick;
   int   tcnt;
   int   total;
   int   bad;
   exp_t sb[$];
   int   q4[$];

   semaforo_cruzamento_param_if #(.N_WAYS(2)) b2();
   semaforo_cruzamento_param_if #(.N_WAYS(4)) b4();

   assign b2.tick = tick;
   assign b4.tick = tick;

   semaforo_cruzamento_param #(.N_WAYS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   semaforo_cruzamento_param #(.N_WAYS(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick = 0;
      tcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         tcnt = (tcnt == 3) ? 0 : tcnt + 1;
         tick = (tcnt == 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   // At most one vehicle lamp lit outside FLASH, never with walk
   always @(negedge clk) begin
      if (!reset) begin
         logic [1:0] v2;
         logic [3:0] v4;
         logic       ok;
         v2 = b2.light_GREEN | b2.light_YELLOW;
         v4 = b4.light_GREEN | b4.light_YELLOW;
         ok = 1'b1;
         if (b2.phase !== FLASH && ($countones(v2) > 1 ||
             (v2 != 0 && b2.p_light_GREEN != 0)))
            ok = 1'b0;
         if (b4.phase !== FLASH && ($countones(v4) > 1 ||
             (v4 != 0 && b4.p_light_GREEN != 0)))
            ok = 1'b0;
         total++;
         if (ok !== 1'b1) begin
            bad++;
            $display("FAIL invariant t=%0t g2=%b y2=%b g4=%b y4=%b",
                     $time, b2.light_GREEN, b2.light_YELLOW,
                     b4.light_GREEN, b4.light_YELLOW);
         end
      end
   end

   task automatic push(input logic [2:0] ph, input logic [2:0] way,
                       input int t, input logic [1:0] pm);
      exp_t e;
      e.ph    = ph;
      e.way   = way;
      e.ticks = 8'(t);
      e.pm    = pm;
      sb.push_back(e);
   endtask

   // Pop each expected phase as the DUT enters it
   task automatic drain(input string tag);
      exp_t e;
      int t;
      int cyc;
      logic [1:0] oh, eg, ey, er, epg, epr;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         oh = 2'b01 << e.way;
         eg = 2'b00; ey = 2'b00; er = 2'b11;
         epg = 2'b00; epr = 2'b11;
         case (e.ph)
            GREEN:  begin eg = oh; er = ~oh; end
            YELLOW: begin ey = oh; er = ~oh; end
            WALK:   begin epg = e.pm; epr = ~e.pm; end
            default: ;
         endcase
         total++;
         if ({b2.phase, b2.cur_way} !== {e.ph, e.way}) begin
            bad++;
            $display("FAIL %s phase/way got=%0d/%0d want=%0d/%0d",
                     tag, b2.phase, b2.cur_way, e.ph, e.way);
         end
         total++;
         if ({b2.light_GREEN, b2.light_YELLOW, b2.light_RED,
              b2.p_light_GREEN, b2.p_light_RED} !==
             {eg, ey, er, epg, epr}) begin
            bad++;
            $display("FAIL %s lamps ph=%0d got=%b want=%b", tag, e.ph,
                     {b2.light_GREEN, b2.light_YELLOW, b2.light_RED,
                      b2.p_light_GREEN, b2.p_light_RED},
                     {eg, ey, er, epg, epr});
         end
         t = 0;
         cyc = 0;
         while (b2.phase === e.ph && cyc < 400) begin
            if (tick) t++;
            @(negedge clk);
            cyc++;
         end
         total++;
         if (t != int'(e.ticks)) begin
            bad++;
            $display("FAIL %s duration ph=%0d got=%0d want=%0d",
                     tag, e.ph, t, e.ticks);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if ({b2.phase, b2.cur_way, b2.light_GREEN, b2.light_YELLOW,
           b2.light_RED, b2.p_light_GREEN, b2.p_light_RED} !==
          {ALLRED, 3'd0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11}) begin
         bad++;
         $display("FAIL reset_values got ph=%0d way=%0d r=%b pr=%b",
                  b2.phase, b2.cur_way, b2.light_RED, b2.p_light_RED);
      end
      @(posedge clk);
      #3 reset = 0;
      @(negedge clk);
   endtask

   task automatic test_rotation;
      push(ALLRED, 0, 2, 0);
      push(GREEN, 0, 20, 0);
      push(YELLOW, 0, 3, 0);
      push(ALLRED, 0, 2, 0);
      push(GREEN, 1, 20, 0);
      push(YELLOW, 1, 3, 0);
      push(ALLRED, 1, 2, 0);
      drain("rotation");
   endtask

   task automatic test_ped;
      push(GREEN, 0, 5, 0);
      push(YELLOW, 0, 3, 0);
      push(ALLRED, 0, 2, 0);
      push(WALK, 0, 8, 2'b10);
      push(ALLRED, 0, 2, 0);
      push(GREEN, 1, 20, 0);
      push(YELLOW, 1, 3, 0);
      push(ALLRED, 1, 2, 0);
      fork
         drain("ped");
         begin
            int n;
            n = 0;
            while (n < 2) begin
               if (tick) n++;
               @(negedge clk);
            end
            b2.botao = 2'b10;
            repeat (3) @(negedge clk);
            b2.botao = 2'b00;
         end
      join
   endtask

   task automatic test_hold;
      push(GREEN, 0, 5, 0);
      push(YELLOW, 0, 3, 0);
      push(ALLRED, 0, 2, 0);
      push(WALK, 0, 8, 2'b01);
      push(ALLRED, 0, 2, 0);
      push(GREEN, 1, 20, 0);
      push(YELLOW, 1, 3, 0);
      push(ALLRED, 1, 2, 0);
      push(GREEN, 0, 20, 0);
      push(YELLOW, 0, 3, 0);
      push(ALLRED, 0, 2, 0);
      fork
         drain("hold");
         begin
            int n;
            b2.botao = 2'b01;
            n = 0;
            while (n < 50) begin
               if (tick) n++;
               @(negedge clk);
            end
            b2.botao = 2'b00;
         end
      join
   endtask

   task automatic test_flash;
      int n;
      int cyc;
      logic [1:0] prev;
      n = 0;
      while (n < 3) begin
         if (tick) n++;
         @(negedge clk);
      end
      b2.flash_mode = 1;
      repeat (2) @(negedge clk);
      total++;
      if (b2.phase !== GREEN) begin
         bad++;
         $display("FAIL flash_early got=%0d want=%0d", b2.phase, GREEN);
      end
      @(negedge clk);
      total++;
      if (b2.phase !== FLASH) begin
         bad++;
         $display("FAIL flash_entry got=%0d want=%0d", b2.phase, FLASH);
      end
      total++;
      if ({b2.light_GREEN, b2.light_YELLOW, b2.light_RED,
           b2.p_light_GREEN, b2.p_light_RED} !== 10'b00_00_00_00_11) begin
         bad++;
         $display("FAIL flash_lamps got=%b want=%b",
                  {b2.light_GREEN, b2.light_YELLOW, b2.light_RED,
                   b2.p_light_GREEN, b2.p_light_RED}, 10'b00_00_00_00_11);
      end
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         while (!tick && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         prev = b2.light_YELLOW;
         @(negedge clk);
         total++;
         if (b2.light_YELLOW !== ~prev) begin
            bad++;
            $display("FAIL flash_blink got=%b want=%b",
                     b2.light_YELLOW, ~prev);
         end
      end
      b2.flash_mode = 0;
      cyc = 0;
      while (b2.phase === FLASH && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      push(ALLRED, 1, 2, 0);
      push(GREEN, 0, 20, 0);
      drain("flash_exit");
   endtask

   task automatic test_reset_mid_walk;
      int cyc;
      b2.botao = 2'b10;
      repeat (3) @(negedge clk);
      b2.botao = 2'b00;
      cyc = 0;
      while (b2.phase !== WALK && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (b2.phase !== WALK) begin
         bad++;
         $display("FAIL walk_reach got=%0d want=%0d", b2.phase, WALK);
      end
      repeat (5) @(negedge clk);
      #3 reset = 1;
      #1;
      total++;
      if ({b2.phase, b2.cur_way, b2.light_GREEN, b2.light_YELLOW,
           b2.light_RED, b2.p_light_GREEN, b2.p_light_RED} !==
          {ALLRED, 3'd0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11}) begin
         bad++;
         $display("FAIL async_reset got ph=%0d pg=%b pr=%b",
                  b2.phase, b2.p_light_GREEN, b2.p_light_RED);
      end
      @(posedge clk);
      #3 reset = 0;
      @(negedge clk);
      push(ALLRED, 0, 2, 0);
      push(GREEN, 0, 20, 0);
      drain("after_reset");
   endtask

   task automatic test_n4;
      int cyc;
      int w;
      logic [2:0] prev;
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 reset = 0;
      q4.push_back(0);
      q4.push_back(1);
      q4.push_back(2);
      q4.push_back(3);
      q4.push_back(0);
      while (q4.size() > 0) begin
         w = q4.pop_front();
         cyc = 0;
         do begin
            prev = b4.phase;
            @(negedge clk);
            cyc++;
         end while (!(b4.phase === GREEN && prev !== GREEN) && cyc < 400);
         total++;
         if (b4.cur_way !== 3'(w)) begin
            bad++;
            $display("FAIL n4_rotation got=%0d want=%0d", b4.cur_way, w);
         end
      end
      b4.botao = 4'b1001;
      repeat (3) @(negedge clk);
      b4.botao = 4'b0000;
      cyc = 0;
      while (b4.phase !== WALK && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if ({b4.p_light_GREEN, b4.p_light_RED, b4.light_RED} !==
          12'b1001_0110_1111) begin
         bad++;
         $display("FAIL n4_walk_mask got=%b want=%b",
                  {b4.p_light_GREEN, b4.p_light_RED, b4.light_RED},
                  12'b1001_0110_1111);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1;
      b2.botao = '0;
      b2.flash_mode = 0;
      b4.botao = '0;
      b4.flash_mode = 0;
      test_reset;
      test_rotation;
      test_ped;
      test_hold;
      test_flash;
      test_reset_mid_walk;
      test_n4;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
